// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_HOLD
    } arb_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle: one valid/data/last/ready lane per producer.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);

    logic [N-1:0]                               req_valid;
    logic [N-1:0][uart_pkg::UART_BYTE_W-1:0]    req_data;
    logic [N-1:0]                               req_last;
    logic [N-1:0]                               req_ready;

    modport master (output req_valid, req_data, req_last, input req_ready);
    modport slave  (input req_valid, req_data, req_last, output req_ready);

endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or after ptr, wrapping mod N.
module uart_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         hit,
    output logic [W-1:0] idx
);

    // Scan farthest-to-nearest so the candidate closest to ptr is assigned last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % N]) begin
                hit = 1'b1;
                idx = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock feeding a single uart_tx serializer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N            = 4,
    parameter int ACK_TIMEOUT  = 64,
    parameter int HOLD_TIMEOUT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_arbiter_if.slave            req,
    output logic [clog2_min1(N)-1:0]    grant_id,
    output logic                        busy,
    output logic                        err_timeout,
    input  logic                        err_clr,
    output logic [UART_BYTE_W-1:0]      tx_data,
    output logic                        tx_start,
    input  logic                        tx_in_progress
);

    localparam int GW    = clog2_min1(N);
    localparam int TMAX  = (ACK_TIMEOUT > HOLD_TIMEOUT) ? ACK_TIMEOUT : HOLD_TIMEOUT;
    localparam int CW    = clog2_min1(TMAX + 1);

    arb_state_t             state, state_nxt;
    logic [GW-1:0]          rr_ptr, ptr_nxt;
    logic [GW-1:0]          grant_nxt;
    logic                   lock, lock_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
    logic [UART_BYTE_W-1:0] data_nxt;
    logic                   start_nxt;
    logic [N-1:0]           ready_nxt;
    logic                   err_set;
    logic                   pick_hit;
    logic [GW-1:0]          pick_idx;
    logic                   cap_ok;
    logic [GW-1:0]          cap_idx;
    logic [GW-1:0]          after_grant;

    uart_rr_pick #(.N(N), .W(GW)) u_pick (
        .valid (req.req_valid),
        .ptr   (rr_ptr),
        .hit   (pick_hit),
        .idx   (pick_idx)
    );

    assign cnt_inc     = cnt + 1'b1;
    assign after_grant = (grant_id == GW'(N - 1)) ? '0 : grant_id + 1'b1;
    assign busy        = (state != ST_IDLE);

    // HOLD only listens to the locked owner; IDLE arbitrates. Both refuse while a frame is live.
    always_comb begin
        cap_ok  = 1'b0;
        cap_idx = pick_idx;
        if (state == ST_IDLE) begin
            cap_ok  = pick_hit && !tx_in_progress;
            cap_idx = pick_idx;
        end else if (state == ST_HOLD) begin
            cap_ok  = req.req_valid[grant_id] && !tx_in_progress;
            cap_idx = grant_id;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = rr_ptr;
        grant_nxt = grant_id;
        lock_nxt  = lock;
        cnt_nxt   = cnt;
        data_nxt  = tx_data;
        start_nxt = 1'b0;
        ready_nxt = '0;
        err_set   = 1'b0;

        unique case (state)
            ST_IDLE, ST_HOLD: begin
                if (cap_ok) begin
                    data_nxt           = req.req_data[cap_idx];
                    ready_nxt[cap_idx] = 1'b1;
                    grant_nxt          = cap_idx;
                    lock_nxt           = ~req.req_last[cap_idx];
                    start_nxt          = 1'b1;
                    state_nxt          = ST_START;
                end else if (state == ST_HOLD && HOLD_TIMEOUT != 0) begin
                    if (cnt_inc == CW'(HOLD_TIMEOUT)) begin
                        err_set   = 1'b1;
                        lock_nxt  = 1'b0;
                        ptr_nxt   = after_grant;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            ST_START: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_in_progress) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (cnt_inc == CW'(ACK_TIMEOUT)) begin
                    err_set   = 1'b1;
                    lock_nxt  = 1'b0;
                    ptr_nxt   = after_grant;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_in_progress) begin
                    if (lock) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_HOLD;
                    end else begin
                        ptr_nxt   = after_grant;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            lock          <= 1'b0;
            cnt           <= '0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
            req.req_ready <= '0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= ptr_nxt;
            grant_id      <= grant_nxt;
            lock          <= lock_nxt;
            cnt           <= cnt_nxt;
            tx_data       <= data_nxt;
            tx_start      <= start_nxt;
            req.req_ready <= ready_nxt;
            // A new timeout in the same cycle as a clear keeps the flag set.
            if (err_set)      err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: requester queues, behavioural uart_tx model, start-order scoreboard.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_timeout;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_in_progress;

    logic       model_en = 1'b1;
    logic       force_ip = 1'b0;
    int         busy_cnt = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] rq[N][$];
    int         tests = 0;
    int         fails = 0;
    int         starts = 0;
    logic       prev_start = 1'b0;

    uart_tx_arbiter_if #(.N(N)) rif ();

    uart_tx_arbiter #(.N(N), .ACK_TIMEOUT(8), .HOLD_TIMEOUT(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (rif),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .err_clr        (err_clr),
        .tx_data        (tx_data),
        .tx_start       (tx_start),
        .tx_in_progress (tx_in_progress)
    );

    always #5 clk = ~clk;

    // uart_tx model: in_progress rises the cycle after start and lasts FRAME cycles
    always @(posedge clk) begin
        if (!model_en)                     busy_cnt <= 0;
        else if (tx_start && busy_cnt == 0) busy_cnt <= FRAME;
        else if (busy_cnt != 0)            busy_cnt <= busy_cnt - 1;
    end
    assign tx_in_progress = model_en ? (busy_cnt != 0) : force_ip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requesters hold valid/data/last until their ready pulse
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rif.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            rif.req_valid[i] <= (rq[i].size() > 0);
            rif.req_data[i]  <= (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            rif.req_last[i]  <= (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
    end

    // Scoreboard: every start must match the next expected (requester, byte)
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (tx_start) begin
                starts <= starts + 1;
                check("start_pulse_width", 32'(prev_start), 32'(0));
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_extra_start: observed data=%0h grant=%0d expected no start", tx_data, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(tx_data), 32'(e.data));
                    check("sb_grant", 32'(grant_id), 32'(e.id));
                    check("sb_ready", 32'(rif.req_ready), 32'(1 << e.id));
                end
            end else if (rif.req_ready != '0) begin
                check("ready_without_start", 32'(rif.req_ready), 32'(0));
            end
        end
        prev_start <= tx_start;
    end

    task automatic load(input int i, input logic [7:0] d, input logic last);
        rq[i].push_back({last, d});
    endtask

    task automatic expect_tx(input int i, input logic [7:0] d);
        exp_t e;
        e.id   = i;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic all_drained();
        logic ok;
        ok = (exp_q.size() == 0) && !busy && !tx_in_progress;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) ok = 1'b0;
        return ok;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!all_drained() && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(all_drained()), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({tx_start, tx_data, rif.req_ready, grant_id, busy, err_timeout}), 32'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_outputs");
        @(negedge clk) rst = 1'b0;

        // Single byte from requester 2, one-cycle latency to ready/start
        @(posedge clk); #1;
        load(2, 8'h55, 1'b1);
        expect_tx(2, 8'h55);
        @(posedge clk); #1;
        check("single_start", 32'(tx_start), 32'(1));
        check("single_ready", 32'(rif.req_ready), 32'(4'b0100));
        check("single_grant", 32'(grant_id), 32'(2));
        check("single_data", 32'(tx_data), 32'(8'h55));
        @(posedge clk); #1;
        check("single_start_drop", 32'(tx_start), 32'(0));
        check("single_busy", 32'(busy), 32'(1));
        wait_idle("single_idle");

        // rr_ptr now 3: requester 3 wins over requester 0
        @(posedge clk); #1;
        load(0, 8'h0A, 1'b1);
        load(3, 8'h3B, 1'b1);
        expect_tx(3, 8'h3B);
        expect_tx(0, 8'h0A);
        wait_idle("ptr_after_single");

        // Round robin from a fresh pointer: 0,1,2,3,0
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        s0 = starts;
        load(0, 8'hA0, 1'b1); load(0, 8'hA4, 1'b1);
        load(1, 8'hA1, 1'b1); load(2, 8'hA2, 1'b1); load(3, 8'hA3, 1'b1);
        expect_tx(0, 8'hA0); expect_tx(1, 8'hA1); expect_tx(2, 8'hA2);
        expect_tx(3, 8'hA3); expect_tx(0, 8'hA4);
        wait_idle("rr_idle");
        check("rr_start_count", 32'(starts - s0), 32'(5));

        // Packet lock: requester 1 keeps the grant across a gap while requester 0 waits
        @(posedge clk); #1;
        s0 = starts;
        load(1, 8'h48, 1'b0);
        load(0, 8'h30, 1'b1);
        expect_tx(1, 8'h48);
        repeat (25) @(posedge clk);
        #1;
        check("lock_hold_busy", 32'(busy), 32'(1));
        check("lock_hold_starts", 32'(starts - s0), 32'(1));
        check("lock_hold_no_ready", 32'(rif.req_ready), 32'(0));
        check("lock_hold_grant", 32'(grant_id), 32'(1));
        load(1, 8'h69, 1'b1);
        expect_tx(1, 8'h69);
        expect_tx(0, 8'h30);
        wait_idle("lock_idle");
        check("lock_start_count", 32'(starts - s0), 32'(3));

        // Ack timeout: uart never acknowledges
        @(posedge clk); #1;
        model_en = 1'b0;
        force_ip = 1'b0;
        load(2, 8'hA5, 1'b1);
        expect_tx(2, 8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 30);
        check("ack_start_seen", 32'(tx_start), 32'(1));
        repeat (8) @(posedge clk);
        #1;
        check("ack_err_not_yet", 32'(err_timeout), 32'(0));
        check("ack_still_busy", 32'(busy), 32'(1));
        @(posedge clk); #1;
        check("ack_err_set", 32'(err_timeout), 32'(1));
        check("ack_back_idle", 32'(busy), 32'(0));
        @(posedge clk); #1;
        check("ack_err_sticky", 32'(err_timeout), 32'(1));
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("ack_err_cleared", 32'(err_timeout), 32'(0));

        // Mid-frame reset while the uart is still sending
        model_en = 1'b1;
        load(0, 8'h11, 1'b1);
        expect_tx(0, 8'h11);
        n = 0;
        while (!(busy && tx_in_progress) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_in_frame", 32'(busy && tx_in_progress), 32'(1));
        @(posedge clk); #1;
        force_ip = 1'b1;
        model_en = 1'b0;
        rst = 1'b1;
        #1 check_all_zero("midrst_outputs");
        load(0, 8'h22, 1'b1);
        expect_tx(0, 8'h22);
        s0 = starts;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_blocked", 32'(starts - s0), 32'(0));
        check("midrst_idle", 32'(busy), 32'(0));
        force_ip = 1'b0;
        model_en = 1'b1;
        wait_idle("midrst_drain");
        check("midrst_one_start", 32'(starts - s0), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
